gray_decode_monitor: RTL and testbench

Receive-side companion to the team's binary-to-Gray counter. It takes a sampled Gray-coded count stream, for example after a clock-domain crossing, converts each sample back to binary, and checks that consecutive samples advance by at most one. It reports decoded values, step errors, a saturating error count and a lock indication to the downstream datapath and to debug registers.

---
 rtl/gray_decode_monitor.sv | 166 ++++++++++++++++
 tb/tb_gray_decode_monitor.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/gray_decode_monitor.sv
// Purpose : decode a sampled Gray count back to binary and flag steps larger than +1.
// Latency : 2 cycles from gray_valid to bin_valid/bin_out/step_err; full rate, one result per cycle.
// Backpr. : none; every valid sample is accepted, and idle cycles hold all tracking state.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   gray_in/gray_valid  Gray-coded sample and its qualifier
//   clr_err             clears err_flag and err_count (a same-cycle step error wins)
//   bin_out/bin_valid   decoded value and one-cycle update pulse
//   step_err            one-cycle pulse with bin_valid when the step was larger than +1
//   err_flag/err_count  sticky error flag and saturating error count
//   locked              LOCK_N consecutive +1 steps seen since the last error or reset
module gray_decode_monitor #(
    parameter int WIDTH  = 4,
    parameter int LOCK_N = 4,
    parameter int ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             gray_valid,
    input  logic             clr_err,
    output logic [WIDTH-1:0] bin_out,
    output logic             bin_valid,
    output logic             step_err,
    output logic             err_flag,
    output logic [ERR_W-1:0] err_count,
    output logic             locked
);

    localparam logic [7:0] LOCK_C = 8'(LOCK_N);

    typedef enum logic {
        ST_ACQUIRE,
        ST_TRACK
    } state_t;

    // Stage 1 capture
    logic [WIDTH-1:0] r_g_q;
    logic             r_v_q;

    // Tracking state
    state_t           r_state;
    logic [WIDTH-1:0] r_prev;
    logic [7:0]       r_good;
    logic             r_locked;

    // Stage 2 outputs
    logic [WIDTH-1:0] r_bin_out;
    logic             r_bin_valid;
    logic             r_step_err;
    logic             r_err_flag;
    logic [ERR_W-1:0] r_err_count;

    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_delta;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_prev_nxt;
    logic [7:0]       w_good_nxt;
    logic             w_locked_nxt;
    logic             w_step_err;

    // Each binary bit is the XOR of all Gray bits at and above it.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_dec
            assign w_b[gi] = ^r_g_q[WIDTH-1:gi];
        end
    endgenerate

    // Modular difference, so a wrap from all-ones to zero is a +1 step.
    assign w_delta = w_b - r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_g_q <= '0;
            r_v_q <= 1'b0;
        end else begin
            r_v_q <= gray_valid;
            if (gray_valid) begin
                r_g_q <= gray_in;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_prev_nxt   = r_prev;
        w_good_nxt   = r_good;
        w_locked_nxt = r_locked;
        w_step_err   = 1'b0;
        if (r_v_q) begin
            case (r_state)
                ST_ACQUIRE: begin
                    // First sample only anchors the reference; nothing to compare against.
                    w_prev_nxt   = w_b;
                    w_good_nxt   = 8'd0;
                    w_locked_nxt = 1'b0;
                    w_state_nxt  = ST_TRACK;
                end
                ST_TRACK: begin
                    if (w_delta == WIDTH'(1)) begin
                        w_prev_nxt = w_b;
                        if (r_good < LOCK_C) begin
                            w_good_nxt = r_good + 8'd1;
                        end
                        if (w_good_nxt >= LOCK_C) begin
                            w_locked_nxt = 1'b1;
                        end
                    end else if (w_delta != '0) begin
                        // Re-anchor on the bad sample so one glitch costs one error.
                        w_step_err   = 1'b1;
                        w_prev_nxt   = w_b;
                        w_good_nxt   = 8'd0;
                        w_locked_nxt = 1'b0;
                    end
                end
                default: w_state_nxt = ST_ACQUIRE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_ACQUIRE;
            r_prev      <= '0;
            r_good      <= 8'd0;
            r_locked    <= 1'b0;
            r_bin_out   <= '0;
            r_bin_valid <= 1'b0;
            r_step_err  <= 1'b0;
            r_err_flag  <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_prev      <= w_prev_nxt;
            r_good      <= w_good_nxt;
            r_locked    <= w_locked_nxt;
            r_bin_valid <= r_v_q;
            r_step_err  <= w_step_err;
            if (r_v_q) begin
                r_bin_out <= w_b;
            end
            // A step error in the same cycle as a clear leaves one error recorded.
            if (w_step_err) begin
                r_err_flag <= 1'b1;
                if (clr_err) begin
                    r_err_count <= ERR_W'(1);
                end else if (r_err_count != {ERR_W{1'b1}}) begin
                    r_err_count <= r_err_count + 1'b1;
                end
            end else if (clr_err) begin
                r_err_flag  <= 1'b0;
                r_err_count <= '0;
            end
        end
    end

    assign bin_out   = r_bin_out;
    assign bin_valid = r_bin_valid;
    assign step_err  = r_step_err;
    assign err_flag  = r_err_flag;
    assign err_count = r_err_count;
    assign locked    = r_locked;

endmodule

// File: tb/tb_gray_decode_monitor.sv
// Purpose : directed check of gray_decode_monitor with WIDTH=4, LOCK_N=4, ERR_W=8.
// Latency : each row drives one cycle and checks the outputs just after that edge.
// Backpr. : none.
module tb_gray_decode_monitor;

    logic       clk;
    logic       rst;
    logic [3:0] gray_in;
    logic       gray_valid;
    logic       clr_err;
    logic [3:0] bin_out;
    logic       bin_valid;
    logic       step_err;
    logic       err_flag;
    logic [7:0] err_count;
    logic       locked;

    int n_checks;
    int n_fail;

    gray_decode_monitor #(
        .WIDTH  (4),
        .LOCK_N (4),
        .ERR_W  (8)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .gray_in    (gray_in),
        .gray_valid (gray_valid),
        .clr_err    (clr_err),
        .bin_out    (bin_out),
        .bin_valid  (bin_valid),
        .step_err   (step_err),
        .err_flag   (err_flag),
        .err_count  (err_count),
        .locked     (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string pfx, input int ebv, input int ebin, input int ese,
                           input int ef, input int ec, input int el);
        chk({pfx, ".bin_valid"}, int'(bin_valid), ebv);
        chk({pfx, ".bin_out"},   int'(bin_out),   ebin);
        chk({pfx, ".step_err"},  int'(step_err),  ese);
        chk({pfx, ".err_flag"},  int'(err_flag),  ef);
        chk({pfx, ".err_count"}, int'(err_count), ec);
        chk({pfx, ".locked"},    int'(locked),    el);
    endtask

    // Drive one cycle of stimulus, then check the outputs produced at that edge
    // (which reflect the sample driven on the previous row).
    task automatic cyc(input int n, input logic v, input logic [3:0] g, input logic clr,
                       input int ebv, input int ebin, input int ese,
                       input int ef, input int ec, input int el);
        gray_valid = v;
        gray_in    = g;
        clr_err    = clr;
        @(posedge clk);
        #1;
        chk_all($sformatf("c%0d", n), ebv, ebin, ese, ef, ec, el);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        gray_in    = 4'b0000;
        gray_valid = 1'b0;
        clr_err    = 1'b0;
        #12;
        chk_all("reset", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        // Count up 0..4 from acquire; lock with the fourth +1 step (bin 4).
        //  n   v     gray    clr   bv bin se  f  c  l
        cyc( 1, 1, 4'b0000, 0,    0,  0, 0, 0, 0, 0);
        cyc( 2, 1, 4'b0001, 0,    1,  0, 0, 0, 0, 0);
        cyc( 3, 1, 4'b0011, 0,    1,  1, 0, 0, 0, 0);
        cyc( 4, 1, 4'b0010, 0,    1,  2, 0, 0, 0, 0);
        cyc( 5, 1, 4'b0110, 0,    1,  3, 0, 0, 0, 0);
        cyc( 6, 0, 4'b0000, 0,    1,  4, 0, 0, 0, 1);
        cyc( 7, 0, 4'b0000, 0,    0,  4, 0, 0, 0, 1);
        // Skip 5 -> 7, then four +1 steps (8..11) to relock.
        cyc( 8, 1, 4'b0111, 0,    0,  4, 0, 0, 0, 1);
        cyc( 9, 1, 4'b0100, 0,    1,  5, 0, 0, 0, 1);
        cyc(10, 1, 4'b1100, 0,    1,  7, 1, 1, 1, 0);
        cyc(11, 1, 4'b1101, 0,    1,  8, 0, 1, 1, 0);
        cyc(12, 1, 4'b1111, 0,    1,  9, 0, 1, 1, 0);
        cyc(13, 1, 4'b1110, 0,    1, 10, 0, 1, 1, 0);
        cyc(14, 0, 4'b0000, 0,    1, 11, 0, 1, 1, 1);
        // Walk 12..15 and wrap to 0, 1.
        cyc(15, 1, 4'b1010, 0,    0, 11, 0, 1, 1, 1);
        cyc(16, 1, 4'b1011, 0,    1, 12, 0, 1, 1, 1);
        cyc(17, 1, 4'b1001, 0,    1, 13, 0, 1, 1, 1);
        cyc(18, 1, 4'b1000, 0,    1, 14, 0, 1, 1, 1);
        cyc(19, 1, 4'b0000, 0,    1, 15, 0, 1, 1, 1);
        cyc(20, 1, 4'b0001, 0,    1,  0, 0, 1, 1, 1);
        // Repeat 2, idle gap of 3, then 3.
        cyc(21, 1, 4'b0011, 0,    1,  1, 0, 1, 1, 1);
        cyc(22, 1, 4'b0011, 0,    1,  2, 0, 1, 1, 1);
        cyc(23, 0, 4'b0000, 0,    1,  2, 0, 1, 1, 1);
        cyc(24, 0, 4'b0000, 0,    0,  2, 0, 1, 1, 1);
        cyc(25, 0, 4'b0000, 0,    0,  2, 0, 1, 1, 1);
        cyc(26, 1, 4'b0010, 0,    0,  2, 0, 1, 1, 1);
        cyc(27, 0, 4'b0000, 0,    1,  3, 0, 1, 1, 1);
        // Clear racing an error (3 -> 5): error wins with count 1, then clear alone.
        cyc(28, 1, 4'b0111, 0,    0,  3, 0, 1, 1, 1);
        cyc(29, 0, 4'b0000, 1,    1,  5, 1, 1, 1, 0);
        cyc(30, 0, 4'b0000, 1,    0,  5, 0, 0, 0, 0);
        // Three errors (5->7, 7->10, 10->13), then four +1 steps to lock.
        cyc(31, 1, 4'b0100, 0,    0,  5, 0, 0, 0, 0);
        cyc(32, 1, 4'b1111, 0,    1,  7, 1, 1, 1, 0);
        cyc(33, 1, 4'b1011, 0,    1, 10, 1, 1, 2, 0);
        cyc(34, 1, 4'b1001, 0,    1, 13, 1, 1, 3, 0);
        cyc(35, 1, 4'b1000, 0,    1, 14, 0, 1, 3, 0);
        cyc(36, 1, 4'b0000, 0,    1, 15, 0, 1, 3, 0);
        cyc(37, 1, 4'b0001, 0,    1,  0, 0, 1, 3, 0);
        cyc(38, 1, 4'b0011, 0,    1,  1, 0, 1, 3, 1);

        // Asynchronous reset between edges with a sample in flight.
        gray_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0, 0);
        #2;
        rst = 1'b0;
        // In-flight sample must be gone; 4 is acquired without a step error.
        cyc(39, 0, 4'b0000, 0,    0,  0, 0, 0, 0, 0);
        cyc(40, 1, 4'b0110, 0,    0,  0, 0, 0, 0, 0);
        cyc(41, 1, 4'b0111, 0,    1,  4, 0, 0, 0, 0);
        cyc(42, 0, 4'b0000, 0,    1,  5, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
